// File: rtl/nonce_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : nonce_result_writer
// Brief    : Snapshots ho[0] of every nonce core on capture and streams the
//            words to result memory at output_addr + nonce index, then pulses
//            done. Optional macro HASH_TARGET_CMP_EN adds a target compare.
// Revision : 1.0 - initial release
// ============================================================================
module nonce_result_writer #(
  parameter int NUM_NONCES = 16,
  parameter int ADDR_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       capture,
  input  logic [NUM_NONCES*32-1:0]   h0_in,
  input  logic [ADDR_W-1:0]          output_addr,
  input  logic                       mem_ready,
`ifdef HASH_TARGET_CMP_EN
  input  logic [31:0]                target,
  output logic                       found,
  output logic [7:0]                 found_nonce,
`endif
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_write_data,
  output logic                       busy,
  output logic                       done
);

  localparam int IDXW = $clog2(NUM_NONCES) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [IDXW-1:0]     r_idx;
  logic [ADDR_W-1:0]   r_base;
  logic [31:0]         r_snap [NUM_NONCES];
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_data;
  logic                r_busy;
  logic                r_done;

  logic                w_take;
  logic                w_accept;
  logic                w_last;
  logic [IDXW-1:0]     w_next_idx;
  logic [31:0]         w_next_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_accept    = r_mem_we & mem_ready;
    w_last      = (r_idx == IDXW'(NUM_NONCES - 1));
    case (r_state)
      S_IDLE: begin
        if (capture) begin
          w_take      = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_accept && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Word for the following index is looked up ahead so address/data stay registered.
  always_comb begin
    w_next_idx  = r_idx + IDXW'(1);
    w_next_data = 32'd0;
    for (int i = 0; i < NUM_NONCES; i++) begin
      if (w_next_idx == IDXW'(i)) begin
        w_next_data = r_snap[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_base     <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < NUM_NONCES; i++) begin
        r_snap[i] <= 32'd0;
      end
    end else begin
      r_done <= 1'b0;
      if (w_take) begin
        r_base     <= output_addr;
        r_idx      <= '0;
        r_busy     <= 1'b1;
        r_mem_we   <= 1'b1;
        r_mem_addr <= output_addr;
        r_mem_data <= h0_in[31:0];
        for (int i = 0; i < NUM_NONCES; i++) begin
          r_snap[i] <= h0_in[i*32 +: 32];
        end
      end else if (r_state == S_WRITE && w_accept) begin
        r_idx <= w_next_idx;
        if (w_last) begin
          r_mem_we <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end else begin
          r_mem_addr <= r_base + ADDR_W'(w_next_idx);
          r_mem_data <= w_next_data;
        end
      end
    end
  end

`ifdef HASH_TARGET_CMP_EN
  logic [31:0] r_target;
  logic        r_found;
  logic [7:0]  r_found_nonce;

  // Only the first hit is recorded, so the lowest nonce below target wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_target      <= 32'd0;
      r_found       <= 1'b0;
      r_found_nonce <= 8'd0;
    end else if (w_take) begin
      r_target      <= target;
      r_found       <= 1'b0;
      r_found_nonce <= 8'd0;
    end else if (r_state == S_WRITE && w_accept && !r_found && (r_mem_data < r_target)) begin
      r_found       <= 1'b1;
      r_found_nonce <= 8'(r_idx);
    end
  end

  assign found       = r_found;
  assign found_nonce = r_found_nonce;
`endif

  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_data;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_nonce_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonce_result_writer
// Brief    : Table-driven and randomized self-checking bench for the result
//            writer, with a transaction-level model of the expected writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonce_result_writer;

  localparam int N  = 16;
  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              capture;
  logic [N*32-1:0]   h0_in;
  logic [AW-1:0]     output_addr;
  logic              mem_ready;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_write_data;
  logic              busy;
  logic              done;
  logic [31:0]       target;
`ifdef HASH_TARGET_CMP_EN
  logic              found;
  logic [7:0]        found_nonce;
`endif

  always #5 clk = ~clk;

  nonce_result_writer #(.NUM_NONCES(N), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .capture        (capture),
    .h0_in          (h0_in),
    .output_addr    (output_addr),
    .mem_ready      (mem_ready),
`ifdef HASH_TARGET_CMP_EN
    .target         (target),
    .found          (found),
    .found_nonce    (found_nonce),
`endif
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .busy           (busy),
    .done           (done)
  );

  typedef struct {
    logic [15:0] base;
    int          dmode;      // 0 A000_0000+n, 1 random, 2 target hits at 9/12, 3 all ones
    int          pct;        // mem_ready probability in percent
    int          stall_idx;
    int          stall_len;
    int          recap_at;
    int          reset_at;
    bit          recap_done;
    logic [31:0] tgt;
    int          exp_done;   // expected done cycle relative to capture, -1 = not fixed
  } vec_t;

  vec_t        tbl[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] hv [N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int dmode);
    for (int i = 0; i < N; i++) begin
      case (dmode)
        0:       hv[i] = 32'hA000_0000 + 32'(i);
        1:       hv[i] = $urandom;
        default: hv[i] = 32'hFFFF_FFFF;
      endcase
    end
    if (dmode == 2) begin
      hv[9]  = 32'h0000_0FFF;
      hv[12] = 32'h0000_0000;
    end
  endtask

  task automatic run(input vec_t v);
    int          exp_idx;
    int          cyc;
    int          stall_left;
    bit          fin;
    bit          exp_found;
    int          exp_fn;
    logic [31:0] snap [N];
    logic [15:0] a;
    exp_idx    = 0;
    stall_left = v.stall_len;
    fin        = 1'b0;
    fill(v.dmode);
    snap = hv;
    exp_found = 1'b0;
    exp_fn    = 0;
    for (int i = 0; i < N; i++) begin
      if (!exp_found && snap[i] < v.tgt) begin
        exp_found = 1'b1;
        exp_fn    = i;
      end
      h0_in[i*32 +: 32] = hv[i];
    end
    output_addr = v.base;
    target      = v.tgt;
    mem_ready   = 1'($urandom);
    capture     = 1'b1;
    tick();
    capture     = 1'b0;
    output_addr = 16'($urandom);
    target      = $urandom;
    cyc = 1;
    while (!fin) begin
      if (cyc > 300) begin
        chk("timeout", 32'(cyc), 32'd0);
        fin = 1'b1;
      end else if (exp_idx < N) begin
        a = v.base + 16'(exp_idx);
        chk("we",   32'(mem_we), 32'd1);
        chk("busy", 32'(busy),   32'd1);
        chk("done", 32'(done),   32'd0);
        chk("addr", 32'(mem_addr), 32'(a));
        chk("data", mem_write_data, snap[exp_idx]);
        if (cyc == v.reset_at) begin
          reset_n = 1'b0;
          #1;
          chk("rst_we",   32'(mem_we), 32'd0);
          chk("rst_busy", 32'(busy),   32'd0);
          tick();
          tick();
          reset_n = 1'b1;
          for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_done", 32'(done),   32'd0);
            chk("post_rst_we",   32'(mem_we), 32'd0);
          end
          fin = 1'b1;
        end else begin
          if (exp_idx == v.stall_idx && stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
          end else begin
            mem_ready = ($urandom_range(99) < v.pct);
          end
          if (cyc == v.recap_at) begin
            capture     = 1'b1;
            output_addr = ~v.base;
            for (int i = 0; i < N; i++) h0_in[i*32 +: 32] = ~hv[i];
          end
          if (mem_ready) exp_idx++;
          tick();
          capture = 1'b0;
          cyc++;
        end
      end else begin
        chk("done_pulse", 32'(done),   32'd1);
        chk("done_we",    32'(mem_we), 32'd0);
        chk("done_busy",  32'(busy),   32'd0);
`ifdef HASH_TARGET_CMP_EN
        chk("found",       32'(found), 32'(exp_found));
        chk("found_nonce", 32'(found_nonce), exp_found ? 32'(exp_fn) : 32'd0);
`endif
        if (v.exp_done > 0) chk("done_cycle", 32'(cyc), 32'(v.exp_done));
        capture   = v.recap_done;
        mem_ready = 1'b1;
        tick();
        capture = 1'b0;
        chk("idle_we",   32'(mem_we), 32'd0);
        chk("idle_busy", 32'(busy),   32'd0);
        chk("idle_done", 32'(done),   32'd0);
`ifdef HASH_TARGET_CMP_EN
        chk("found_hold", 32'(found), 32'(exp_found));
`endif
        fin = 1'b1;
      end
    end
  endtask

  initial begin
    tbl.push_back('{16'h0100, 0, 100, -1, 0, -1, -1, 1'b0, 32'h0, 17});
    tbl.push_back('{16'h0100, 0, 100,  5, 3, -1, -1, 1'b0, 32'h0, 20});
    tbl.push_back('{16'hFFFE, 0, 100, -1, 0, -1, -1, 1'b1, 32'h0, 17});
    tbl.push_back('{16'h0100, 0, 100, -1, 0,  4, -1, 1'b0, 32'h0, 17});
    tbl.push_back('{16'h0100, 0, 100, -1, 0, -1,  8, 1'b0, 32'h0, -1});
    tbl.push_back('{16'h0100, 0, 100, -1, 0, -1, -1, 1'b0, 32'h0, 17});
    for (int r = 0; r < 4; r++) begin
      tbl.push_back('{16'($urandom), 1, 60, -1, 0, -1, -1, 1'($urandom), $urandom, -1});
    end
`ifdef HASH_TARGET_CMP_EN
    tbl.push_back('{16'h0200, 2, 100, -1, 0, -1, -1, 1'b0, 32'h0000_1000, 17});
    tbl.push_back('{16'h0200, 3, 100, -1, 0, -1, -1, 1'b0, 32'h0000_1000, 17});
`endif

    reset_n     = 1'b0;
    capture     = 1'b0;
    mem_ready   = 1'b0;
    h0_in       = '0;
    output_addr = '0;
    target      = 32'd0;
    tick();
    tick();
    chk("reset_we",   32'(mem_we), 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    chk("reset_data", mem_write_data, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
`ifdef HASH_TARGET_CMP_EN
    chk("reset_found", 32'(found), 32'd0);
    chk("reset_found_nonce", 32'(found_nonce), 32'd0);
`endif
    reset_n = 1'b1;
    tick();

    for (int t = 0; t < tbl.size(); t++) begin
      run(tbl[t]);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
